// File: rtl/quiz_round_ctrl.sv
//------------------------------------------------------------------------------
// Module  : quiz_round_ctrl
// Brief   : Quiz game round sequencer: timer enable, answer/timeout scoring,
//           round counting and game-over. Optional macro QUIZ_PENALTY_EN
//           subtracts SCORE_BASE (floored at 0) on a wrong answer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module quiz_round_ctrl #(
    parameter int MAX_ROUNDS = 10,
    parameter int SCORE_BASE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       round_start,
    input  logic       answer_valid,
    input  logic       answer_correct,
    input  logic [3:0] time_left,
    input  logic       timer_done,
    output logic       start_timer,
    output logic       result_valid,
    output logic [1:0] result_code,
    output logic [7:0] score,
    output logic [3:0] rounds_played,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        COOL = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [9:0] C_BASE = 10'(SCORE_BASE);
    localparam logic [3:0] C_MAX  = 4'(MAX_ROUNDS);

    state_t     r_state;
    logic       r_cool_cnt;
    logic [9:0] w_sum;
    logic [7:0] w_score_ok;
    logic [7:0] w_score_bad;

    // Ten-bit sum leaves headroom for 255 + SCORE_BASE + 10 before saturating.
    assign w_sum      = {2'b00, score} + C_BASE + {6'd0, time_left};
    assign w_score_ok = (w_sum > 10'd255) ? 8'hFF : w_sum[7:0];

`ifdef QUIZ_PENALTY_EN
    logic [9:0] w_diff;
    assign w_diff      = {2'b00, score} - C_BASE;
    assign w_score_bad = ({2'b00, score} >= C_BASE) ? w_diff[7:0] : 8'd0;
`else
    assign w_score_bad = score;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cool_cnt    <= 1'b0;
            start_timer   <= 1'b0;
            result_valid  <= 1'b0;
            result_code   <= 2'b00;
            score         <= 8'd0;
            rounds_played <= 4'd0;
            game_over     <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (round_start) begin
                        r_state     <= WAIT;
                        start_timer <= 1'b1;
                    end
                end
                WAIT: begin
                    // An answer arriving with the timeout takes precedence.
                    if (answer_valid || timer_done) begin
                        r_state       <= COOL;
                        r_cool_cnt    <= 1'b0;
                        start_timer   <= 1'b0;
                        result_valid  <= 1'b1;
                        rounds_played <= rounds_played + 4'd1;
                        if (!answer_valid) begin
                            result_code <= 2'b11;
                        end else if (answer_correct) begin
                            result_code <= 2'b01;
                            score       <= w_score_ok;
                        end else begin
                            result_code <= 2'b10;
                            score       <= w_score_bad;
                        end
                    end
                end
                COOL: begin
                    r_cool_cnt <= 1'b1;
                    if (r_cool_cnt) begin
                        if (rounds_played == C_MAX) begin
                            r_state   <= DONE;
                            game_over <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    if (round_start) begin
                        r_state       <= WAIT;
                        start_timer   <= 1'b1;
                        score         <= 8'd0;
                        rounds_played <= 4'd0;
                        game_over     <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_quiz_round_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_quiz_round_ctrl
// Brief   : Scoreboard bench for quiz_round_ctrl with a round-level game model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_quiz_round_ctrl;

    localparam int MAXR = 4;
    localparam int SB   = 70;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       round_start = 1'b0;
    logic       answer_valid = 1'b0;
    logic       answer_correct = 1'b0;
    logic [3:0] time_left = 4'd0;
    logic       timer_done = 1'b0;
    logic       start_timer;
    logic       result_valid;
    logic [1:0] result_code;
    logic [7:0] score;
    logic [3:0] rounds_played;
    logic       game_over;

    typedef struct packed {
        logic [1:0] code;
        logic [7:0] score;
        logic [3:0] rounds;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_score = 0;
    int         m_rounds = 0;
    logic [1:0] last_code = 2'b00;

    quiz_round_ctrl #(.MAX_ROUNDS(MAXR), .SCORE_BASE(SB)) dut (
        .clk           (clk),
        .rst           (rst),
        .round_start   (round_start),
        .answer_valid  (answer_valid),
        .answer_correct(answer_correct),
        .time_left     (time_left),
        .timer_done    (timer_done),
        .start_timer   (start_timer),
        .result_valid  (result_valid),
        .result_code   (result_code),
        .score         (score),
        .rounds_played (rounds_played),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-result monitor: every strobe must match the oldest queued outcome.
    always @(negedge clk) begin
        if (rst) begin
            last_code = 2'b00;
        end else if (result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=code%0d expected=none", result_code);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_code", 32'(result_code), 32'(e.code));
                chk("result_score", 32'(score), 32'(e.score));
                chk("result_rounds", 32'(rounds_played), 32'(e.rounds));
                last_code = e.code;
            end
        end else begin
            chk("code_hold", 32'(result_code), 32'(last_code));
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_start_timer"}, 32'(start_timer), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_result_code"}, 32'(result_code), 0);
        chk({tag, "_score"}, 32'(score), 0);
        chk({tag, "_rounds"}, 32'(rounds_played), 0);
        chk({tag, "_game_over"}, 32'(game_over), 0);
    endtask

    // kind: 0 correct, 1 wrong, 2 timeout, 3 answer+timeout together
    task automatic play_round(input int kind, input int t, input int waitc, input bit noise);
        bit   was_done;
        bit   correct;
        exp_t e;
        was_done = (m_rounds == MAXR);
        if (noise) begin
            answer_valid = 1'($urandom % 2);
            timer_done   = 1'($urandom % 2);
            tick();
            answer_valid = 1'b0;
            timer_done   = 1'b0;
            chk("idle_timer_off", 32'(start_timer), 0);
        end
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        if (was_done) begin
            m_score  = 0;
            m_rounds = 0;
        end
        chk("start_timer_on", 32'(start_timer), 1);
        chk("start_score", 32'(score), 32'(m_score));
        chk("start_rounds", 32'(rounds_played), 32'(m_rounds));
        chk("start_game_over", 32'(game_over), 0);
        repeat (waitc) begin
            round_start = 1'($urandom % 2);
            time_left   = 4'($urandom_range(0, 10));
            tick();
            chk("wait_timer_on", 32'(start_timer), 1);
        end
        round_start = 1'b0;
        time_left   = 4'(t);
        correct     = (kind == 0) || (kind == 3 && ($urandom % 2) == 1);
        answer_valid   = (kind != 2);
        answer_correct = correct;
        timer_done     = (kind >= 2);
        if (kind == 2) begin
            e.code = 2'b11;
        end else if (correct) begin
            e.code  = 2'b01;
            m_score = (m_score + SB + t > 255) ? 255 : m_score + SB + t;
        end else begin
            e.code = 2'b10;
`ifdef QUIZ_PENALTY_EN
            m_score = (m_score < SB) ? 0 : m_score - SB;
`endif
        end
        m_rounds++;
        e.score  = 8'(m_score);
        e.rounds = 4'(m_rounds);
        sb_q.push_back(e);
        tick();
        answer_valid = 1'b0;
        timer_done   = 1'b0;
        chk("cool_timer_off_1", 32'(start_timer), 0);
        for (int c = 0; c < 2; c++) begin
            round_start  = 1'($urandom % 2);
            answer_valid = 1'($urandom % 2);
            timer_done   = 1'($urandom % 2);
            tick();
        end
        round_start  = 1'b0;
        answer_valid = 1'b0;
        timer_done   = 1'b0;
        chk("cool_timer_off_2", 32'(start_timer), 0);
        chk("game_over", 32'(game_over), 32'(m_rounds == MAXR));
    endtask

    task automatic reset_in_wait();
        round_start = 1'b1;
        tick();
        round_start = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_score  = 0;
        m_rounds = 0;
        tick();
        rst = 1'b0;
        play_round(0, 10, 1, 1'b0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Directed opening game, then mixed random play.
        play_round(0, 7, 0, 1'b0);
        play_round(2, 3, 2, 1'b1);
        play_round(3, 0, 1, 1'b1);
        play_round(1, 5, 0, 1'b1);
        play_round(0, 10, 0, 1'b1);
        play_round(0, 10, 1, 1'b1);
        play_round(0, 10, 0, 1'b1);
        play_round(0, 9, 0, 1'b1);
        play_round(1, 2, 0, 1'b1);
        reset_in_wait();
        for (int i = 0; i < 80; i++) begin
            play_round($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 3), 1'b1);
        end
        repeat (3) tick();
        chk("queue_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 The module SHALL have parameter MAX_ROUNDS, default 10, meaning the number of rounds per game (1-15).
REQ-002 The module SHALL have parameter SCORE_BASE, default 2, meaning the points awarded per correct answer before the time bonus.
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port round_start, input, 1 bit: one-cycle request to begin a round.
REQ-006 The module SHALL have ports answer_valid and answer_correct, input, 1 bit each: an answer submission strobe and its correctness flag.
REQ-007 The module SHALL have ports time_left (input, 4 bits, seconds remaining 0-10) and timer_done (input, 1 bit, countdown-expired pulse), both from the countdown timer.
REQ-008 The module SHALL have port start_timer, output, 1 bit: level enable to the countdown timer.
REQ-009 The module SHALL have port result_valid, output, 1 bit: one-cycle round-result strobe.
REQ-010 The module SHALL have port result_code, output, 2 bits: 01 correct, 10 wrong, 11 timeout, 00 none.
REQ-011 The module SHALL have ports score (output, 8 bits, game score), rounds_played (output, 4 bits, completed rounds) and game_over (output, 1 bit, game-complete level).

Function
REQ-012 The module SHALL implement states IDLE, WAIT, COOL and DONE.
REQ-013 IDLE with round_start=1 SHALL go to WAIT, with start_timer=1 from the next cycle (1-cycle latency).
REQ-014 In WAIT, start_timer SHALL be 1; round_start SHALL be ignored.
REQ-015 In WAIT, answer_valid=1 SHALL go to COOL, drive result_valid=1 for one cycle and set result_code to 01 or 10 per answer_correct.
REQ-016 In WAIT, timer_done=1 with answer_valid=0 SHALL go to COOL with result_valid=1 and result_code=11.
REQ-017 If answer_valid and timer_done are both 1 in the same WAIT cycle, the answer SHALL win.
REQ-018 A correct answer SHALL add SCORE_BASE + time_left (value sampled in the answer cycle) to score, saturating at 255, in the same cycle result_valid rises.
REQ-019 A wrong answer or a timeout SHALL leave score unchanged, subject to REQ-029.
REQ-020 rounds_played SHALL increment in the same cycle result_valid rises.
REQ-021 In COOL, start_timer SHALL be 0 for exactly 2 cycles, so the timer returns to its idle state; COOL SHALL then go to DONE if rounds_played==MAX_ROUNDS, else to IDLE.
REQ-022 In DONE, game_over SHALL be 1; round_start SHALL clear score and rounds_played, drop game_over and go to WAIT.
REQ-023 answer_valid and timer_done SHALL be ignored outside WAIT; round_start SHALL be ignored in COOL.
REQ-024 result_code SHALL hold its last value until the next result_valid.

Reset
REQ-025 While rst=1, the state SHALL be IDLE and start_timer, result_valid, result_code, score, rounds_played and game_over SHALL all be 0, independent of clk.
REQ-026 A reset asserted in WAIT SHALL drop start_timer immediately (asynchronously) and discard the round in progress.
REQ-027 After rst deasserts, the first round_start SHALL be honoured on the first rising edge.

Configuration
REQ-028 The macro QUIZ_PENALTY_EN SHALL enable or disable the wrong-answer penalty.
REQ-029 With QUIZ_PENALTY_EN defined, a wrong answer SHALL subtract SCORE_BASE from score, floored at 0.
REQ-030 Without QUIZ_PENALTY_EN, a wrong answer SHALL leave score unchanged, and no penalty logic SHALL be synthesised.

Verification
REQ-031 Reset, then round_start; time_left=7, answer_valid=1, answer_correct=1 -> result_code=01, score=9, rounds_played=1, start_timer low for 2 cycles.
REQ-032 round_start, then timer_done pulse with no answer -> result_code=11, score unchanged, rounds_played+1.
REQ-033 answer_valid and timer_done in the same cycle with answer_correct=1 and time_left=0 -> result_code=01, score+=2.
REQ-034 With QUIZ_PENALTY_EN and score=1, a wrong answer -> score=0; without the macro -> score=1.
REQ-035 MAX_ROUNDS=3, three rounds played -> game_over=1 after COOL; round_start -> score=0, rounds_played=0, start_timer=1.
REQ-036 Score at 250, correct answer with time_left=10 -> score=255 (saturated); rst during WAIT -> start_timer=0 immediately, all outputs 0.
